// File: rtl/fc_result_reader_pkg.sv
// rtl/fc_result_reader_pkg.sv - shared FSM encoding and read-map constants for the FC result reader
package fc_result_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SCAN    = 2'd2,
        ST_DONE    = 2'd3
    } frr_state_t;

    localparam int         FRR_NUM_CLASSES = 10;
    localparam logic [3:0] FRR_ADDR_CLASS  = 4'd10;
    localparam logic [3:0] FRR_ADDR_STATUS = 4'd11;

endpackage

// File: rtl/fc_result_reader_score_key_cmp.sv
// rtl/fc_result_reader_score_key_cmp.sv - combinational score comparator, a strictly greater than b
module score_key_cmp #(
    parameter int ARITH_TYPE = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_a_gt_b
);

    generate
        if (ARITH_TYPE == 1) begin : g_float
            // Maps IEEE-754 bit patterns onto a monotonic unsigned key; NaNs fall where their bits put them.
            logic [DATA_WIDTH-1:0] w_key_a;
            logic [DATA_WIDTH-1:0] w_key_b;
            assign w_key_a  = i_a[DATA_WIDTH-1] ? ~i_a : {1'b1, i_a[DATA_WIDTH-2:0]};
            assign w_key_b  = i_b[DATA_WIDTH-1] ? ~i_b : {1'b1, i_b[DATA_WIDTH-2:0]};
            assign o_a_gt_b = w_key_a > w_key_b;
        end else begin : g_fixed
            assign o_a_gt_b = $signed(i_a) > $signed(i_b);
        end
    endgenerate

endmodule

// File: rtl/fc_result_reader.sv
// rtl/fc_result_reader.sv - captures FC2 scores, runs a sequential argmax, exposes results to the host
module fc_result_reader
    import fc_result_reader_pkg::*;
#(
    parameter int ARITH_TYPE   = 1,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CLASSES  = FRR_NUM_CLASSES,
    parameter int INDEX_WIDTH  = $clog2(NUM_CLASSES),
    parameter int ADDRESS_BITS = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_from_previous,
    input  logic [DATA_WIDTH-1:0]   data_in_1,
    input  logic [DATA_WIDTH-1:0]   data_in_2,
    input  logic [DATA_WIDTH-1:0]   data_in_3,
    input  logic [DATA_WIDTH-1:0]   data_in_4,
    input  logic [DATA_WIDTH-1:0]   data_in_5,
    input  logic [DATA_WIDTH-1:0]   data_in_6,
    input  logic [DATA_WIDTH-1:0]   data_in_7,
    input  logic [DATA_WIDTH-1:0]   data_in_8,
    input  logic [DATA_WIDTH-1:0]   data_in_9,
    input  logic [DATA_WIDTH-1:0]   data_in_10,
    output logic                    end_to_previous,
    input  logic [ADDRESS_BITS-1:0] riscv_address,
    input  logic                    riscv_rd_en,
    output logic [DATA_WIDTH-1:0]   riscv_rdata,
    input  logic                    riscv_clear,
    output logic                    busy,
    output logic                    result_valid,
    output logic [INDEX_WIDTH-1:0]  class_index,
    output logic                    done_irq
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

    frr_state_t            r_state;
    frr_state_t            w_next;
    logic [DATA_WIDTH-1:0] r_score [NUM_CLASSES];
    logic [DATA_WIDTH-1:0] w_in [FRR_NUM_CLASSES];
    logic [DATA_WIDTH-1:0] r_best;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [INDEX_WIDTH-1:0] r_best_idx;
    logic [INDEX_WIDTH-1:0] r_class_index;
    logic [3:0]            w_rd_sel;
    logic                  r_done_irq;
    logic                  w_gt;
    logic                  w_capture;
    logic                  w_last;
    logic                  w_unused_addr;

    assign w_in[0] = data_in_1;
    assign w_in[1] = data_in_2;
    assign w_in[2] = data_in_3;
    assign w_in[3] = data_in_4;
    assign w_in[4] = data_in_5;
    assign w_in[5] = data_in_6;
    assign w_in[6] = data_in_7;
    assign w_in[7] = data_in_8;
    assign w_in[8] = data_in_9;
    assign w_in[9] = data_in_10;

    // Scores are latched on the edge that leaves IDLE/DONE, while FC2 still drives them.
    assign w_capture     = start_from_previous && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last        = (r_idx == LAST_IDX);
    assign w_rd_sel      = riscv_address[3:0];
    assign w_unused_addr = ^riscv_address[ADDRESS_BITS-1:4];

    score_key_cmp #(
        .ARITH_TYPE (ARITH_TYPE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .i_a      (r_score[r_idx]),
        .i_b      (r_best),
        .o_a_gt_b (w_gt)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start_from_previous) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_SCAN;
            ST_SCAN:    if (w_last) w_next = ST_DONE;
            ST_DONE: begin
                if (start_from_previous) w_next = ST_CAPTURE;
                else if (riscv_clear)    w_next = ST_IDLE;
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        end_to_previous = (r_state == ST_CAPTURE);
        busy            = (r_state == ST_CAPTURE) || (r_state == ST_SCAN);
        result_valid    = (r_state == ST_DONE);
        done_irq        = r_done_irq;
        class_index     = r_class_index;
        riscv_rdata     = r_rdata;
    end

    always_comb begin
        w_rd_data = '0;
        if (32'(w_rd_sel) < NUM_CLASSES)      w_rd_data = r_score[w_rd_sel];
        else if (w_rd_sel == FRR_ADDR_CLASS)  w_rd_data = DATA_WIDTH'(r_class_index);
        else if (w_rd_sel == FRR_ADDR_STATUS) w_rd_data = DATA_WIDTH'({busy, result_valid});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_score[i] <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_idx         <= '0;
            r_class_index <= '0;
            r_done_irq    <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_done_irq <= 1'b0;
            if (w_capture) begin
                for (int i = 0; i < NUM_CLASSES; i++) r_score[i] <= w_in[i];
            end
            if (r_state == ST_CAPTURE) begin
                r_best     <= r_score[0];
                r_best_idx <= '0;
                r_idx      <= INDEX_WIDTH'(1);
            end else if (r_state == ST_SCAN) begin
                if (w_gt) begin
                    r_best     <= r_score[r_idx];
                    r_best_idx <= r_idx;
                end
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    r_class_index <= w_gt ? r_idx : r_best_idx;
                    r_done_irq    <= 1'b1;
                end
            end
            if (riscv_rd_en) r_rdata <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_fc_result_reader.sv
// tb/tb_fc_result_reader.sv - self-checking bench for fc_result_reader in fixed and float modes
module tb_fc_result_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr = 1'b0;
    logic [14:0] addr = '0;
    logic [31:0] d [10];

    logic        fix_etp, fix_busy, fix_rv, fix_irq;
    logic [3:0]  fix_ci;
    logic [31:0] fix_rd;
    logic        flt_etp, flt_busy, flt_rv, flt_irq;
    logic [3:0]  flt_ci;
    logic [31:0] flt_rd;

    int checks = 0;
    int errors = 0;
    int q_fix [$];
    int q_flt [$];

    typedef struct {
        bit          flt;
        logic [31:0] sc [10];
        int          exp_idx;
    } vec_t;
    vec_t vt [4];
    logic [31:0] garbage [10];
    logic [31:0] max9 [10];

    always #5 clk = ~clk;

    fc_result_reader #(.ARITH_TYPE(0)) u_fix (
        .clk(clk), .reset(reset), .start_from_previous(start),
        .data_in_1(d[0]), .data_in_2(d[1]), .data_in_3(d[2]), .data_in_4(d[3]), .data_in_5(d[4]),
        .data_in_6(d[5]), .data_in_7(d[6]), .data_in_8(d[7]), .data_in_9(d[8]), .data_in_10(d[9]),
        .end_to_previous(fix_etp), .riscv_address(addr), .riscv_rd_en(rd_en), .riscv_rdata(fix_rd),
        .riscv_clear(clr), .busy(fix_busy), .result_valid(fix_rv), .class_index(fix_ci), .done_irq(fix_irq)
    );

    fc_result_reader #(.ARITH_TYPE(1)) u_flt (
        .clk(clk), .reset(reset), .start_from_previous(start),
        .data_in_1(d[0]), .data_in_2(d[1]), .data_in_3(d[2]), .data_in_4(d[3]), .data_in_5(d[4]),
        .data_in_6(d[5]), .data_in_7(d[6]), .data_in_8(d[7]), .data_in_9(d[8]), .data_in_10(d[9]),
        .end_to_previous(flt_etp), .riscv_address(addr), .riscv_rd_en(rd_en), .riscv_rdata(flt_rd),
        .riscv_clear(clr), .busy(flt_busy), .result_valid(flt_rv), .class_index(flt_ci), .done_irq(flt_irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b, input bit flt);
        if (!flt)         return $signed(a) > $signed(b);
        if (a[31] != b[31]) return b[31];
        if (!a[31])       return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    function automatic int ref_argmax(input bit flt);
        int best = 0;
        for (int i = 1; i < 10; i++) if (ref_gt(d[i], d[best], flt)) best = i;
        return best;
    endfunction

    always @(negedge clk) begin
        if (fix_irq) begin
            if (q_fix.size() == 0) chk("fix_sb_empty", 32'd1, 32'd0);
            else chk("fix_sb_class", 32'(fix_ci), 32'(q_fix.pop_front()));
        end
        if (flt_irq) begin
            if (q_flt.size() == 0) chk("flt_sb_empty", 32'd1, 32'd0);
            else chk("flt_sb_class", 32'(flt_ci), 32'(q_flt.pop_front()));
        end
    end

    // Start sampled in cycle T; loop index k counts cycles after T, sampled mid-cycle.
    task automatic run_frame(input int poke_k, input bit with_clear);
        int bad_etp = 0, bad_busy = 0, bad_rv = 0, bad_irq = 0;
        @(negedge clk);
        start = 1'b1;
        clr   = with_clear;
        q_fix.push_back(ref_argmax(1'b0));
        q_flt.push_back(ref_argmax(1'b1));
        @(posedge clk);
        #1 start = 1'b0;
        clr = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (fix_etp !== (k == 1) || flt_etp !== (k == 1)) bad_etp++;
            if (fix_busy !== (k <= 10) || flt_busy !== (k <= 10)) bad_busy++;
            if (fix_rv !== (k >= 11) || flt_rv !== (k >= 11)) bad_rv++;
            if (fix_irq !== (k == 11) || flt_irq !== (k == 11)) bad_irq++;
            if (k == poke_k) begin
                start = 1'b1;
                for (int i = 0; i < 10; i++) d[i] = garbage[i];
            end else begin
                start = 1'b0;
            end
        end
        chk("etp_timing", 32'(bad_etp), 32'd0);
        chk("busy_timing", 32'(bad_busy), 32'd0);
        chk("rv_timing", 32'(bad_rv), 32'd0);
        chk("irq_timing", 32'(bad_irq), 32'd0);
    endtask

    task automatic rd(input logic [3:0] a);
        @(negedge clk);
        addr  = {11'd0, a};
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] s [10]);
        for (int i = 0; i < 10; i++) d[i] = s[i];
    endtask

    initial begin
        int irq_seen;
        vt[0].flt = 1'b0; vt[0].exp_idx = 2;
        vt[0].sc  = '{32'hFFFF_FFFB, 32'd3, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd2, 32'd6, 32'd1, 32'hFFFF_FFF8};
        vt[1].flt = 1'b1; vt[1].exp_idx = 8;
        vt[1].sc  = '{32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h8000_0000,
                      32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hBF80_0000};
        vt[2].flt = 1'b1; vt[2].exp_idx = 0;
        for (int i = 0; i < 10; i++) vt[2].sc[i] = 32'h4040_0000;
        vt[3].flt = 1'b0; vt[3].exp_idx = 3;
        vt[3].sc  = '{32'hFFFF_FFF7, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                      32'hFFFF_FF9C, 32'hFFFF_FFCE, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 32'hFFFF_FFF8};
        for (int i = 0; i < 10; i++) begin
            garbage[i] = (i == 5) ? 32'h7FFF_FFFF : 32'd0;
            max9[i]    = (i == 9) ? 32'd100 : 32'(i + 1);
            d[i]       = '0;
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_fix_outs", {26'd0, fix_etp, fix_busy, fix_rv, fix_irq, fix_ci}, 32'd0);
        chk("reset_flt_outs", {26'd0, flt_etp, flt_busy, flt_rv, flt_irq, flt_ci}, 32'd0);
        chk("reset_fix_rdata", fix_rd, 32'd0);
        chk("reset_flt_rdata", flt_rd, 32'd0);

        for (int v = 0; v < 4; v++) begin
            load(vt[v].sc);
            run_frame(0, 1'b0);
            chk($sformatf("vec%0d_class", v), vt[v].flt ? 32'(flt_ci) : 32'(fix_ci), 32'(vt[v].exp_idx));
            if (v == 1) begin
                rd(4'd10);
                chk("rd_class_addr10", flt_rd, 32'd8);
            end
            if (v < 3) do_clear();
        end

        rd(4'd11);
        chk("rd_status_done", fix_rd, 32'd1);
        rd(4'd5);
        chk("rd_score5", fix_rd, vt[3].sc[5]);
        @(negedge clk) addr = 15'd0;
        @(negedge clk);
        chk("rdata_hold", fix_rd, vt[3].sc[5]);
        do_clear();
        chk("clear_rv", {31'd0, fix_rv | flt_rv}, 32'd0);
        chk("clear_keeps_class", 32'(fix_ci), 32'd3);
        rd(4'd11);
        chk("rd_status_cleared", fix_rd, 32'd0);

        load(vt[2].sc);
        run_frame(4, 1'b0);
        chk("retrig_ignored_class", 32'(fix_ci), 32'd0);
        load(max9);
        run_frame(0, 1'b0);
        chk("retrig_done_class", 32'(fix_ci), 32'd9);

        load(vt[1].sc);
        run_frame(0, 1'b1);
        chk("clear_start_class", 32'(flt_ci), 32'd8);

        load(vt[0].sc);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        irq_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (fix_irq || flt_irq || (k > 6 && (fix_etp || flt_etp))) irq_seen++;
            if (k == 5) reset = 1'b1;
            if (k == 6) begin
                chk("midscan_fix_outs", {26'd0, fix_etp, fix_busy, fix_rv, fix_irq, fix_ci}, 32'd0);
                chk("midscan_flt_outs", {26'd0, flt_etp, flt_busy, flt_rv, flt_irq, flt_ci}, 32'd0);
                chk("midscan_rdata", fix_rd | flt_rd, 32'd0);
                reset = 1'b0;
            end
        end
        chk("midscan_no_irq", 32'(irq_seen), 32'd0);
        run_frame(0, 1'b0);
        chk("after_reset_class", 32'(fix_ci), 32'd2);

        repeat (2) @(negedge clk);
        chk("sb_fix_drained", 32'(q_fix.size()), 32'd0);
        chk("sb_flt_drained", 32'(q_flt.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_result_reader.md
Name: fc_result_reader

Overview:
- Downstream consumer of the FC2 classifier layer's 10 score outputs.
- Captures the scores when the layer signals output_ready, then releases the layer via end_to_previous.
- Runs a sequential argmax over the captured scores to find the winning class.
- Exposes scores, class index and status to the RISC-V host through a registered read port; raises a one-cycle done interrupt.

Parameters:
- ARITH_TYPE, 1, 1 = IEEE-754 single compare; 0 = signed two's-complement fixed-point compare.
- DATA_WIDTH, 32, score word width.
- NUM_CLASSES, 10, number of scores captured.
- INDEX_WIDTH, $clog2(NUM_CLASSES), width of class index.
- ADDRESS_BITS, 15, RISC-V address width (low 4 bits decoded).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- start_from_previous  input  1  FC2 output_ready; level, sampled each cycle.
- data_in_1 .. data_in_10  input  DATA_WIDTH each  FC2 reg_out_FC_1..10, valid while start_from_previous is high.
- end_to_previous  output  1  one-cycle pulse: scores captured, FC2 may proceed.
- riscv_address  input  ADDRESS_BITS  read address.
- riscv_rd_en  input  1  read strobe.
- riscv_rdata  output  DATA_WIDTH  read data, 1-cycle latency.
- riscv_clear  input  1  acknowledge: drops result_valid.
- busy  output  1  high in CAPTURE/SCAN.
- result_valid  output  1  argmax result held.
- class_index  output  INDEX_WIDTH  winning class, 0-based.
- done_irq  output  1  one-cycle pulse when result_valid rises.

Behaviour:
- Reset: all outputs 0, score regs 0, FSM IDLE.
- FSM states and transitions:
  - IDLE: start_from_previous=1 → CAPTURE.
  - CAPTURE: 1 cycle. Latch data_in_1..10 into score[0..9]. Set best=score[0], best_idx=0, scan idx=1 → SCAN.
  - SCAN: one compare per cycle for idx=1..9. If key(score[idx]) > key(best), update best and best_idx. After idx=9 → DONE.
  - DONE: result_valid=1, class_index=best_idx.
    - riscv_clear → IDLE (result_valid=0).
    - start_from_previous=1 → CAPTURE (result_valid=0, new frame).
    - Both in the same cycle: start wins.
- Timing, with start sampled in IDLE at cycle T:
  - Capture edge ends cycle T; end_to_previous high for exactly cycle T+1.
  - Scan occupies cycles T+2..T+10.
  - result_valid and done_irq rise at T+11; done_irq lasts one cycle.
- start_from_previous while busy: ignored; no end_to_previous. FC2 holds output_ready until released.
- Compare key:
  - ARITH_TYPE=1: key = sign ? ~x : x ^ (1<<(DATA_WIDTH-1)), unsigned compare. +0 ranks above -0. NaN is ordered by raw bits, with no special casing.
  - ARITH_TYPE=0: signed compare.
- Ties (equal keys): lowest index wins (strict >).
- class_index holds its last value until the next CAPTURE; it is not cleared by riscv_clear.
- Read map: low 4 address bits select.
  - 0..9 → score[n].
  - 10 → zero-extended class_index.
  - 11 → {zeros, busy, result_valid}.
  - 12..15 → 0.
  - riscv_rdata updates only on riscv_rd_en and holds otherwise.
  - Reads are legal in any state and return current register contents; during SCAN these are the newly captured scores.
- Reset mid-SCAN: abort, back to IDLE, no end_to_previous, no done_irq.

Decomposition:
- Shared package: FSM state encoding (IDLE, CAPTURE, SCAN, DONE), read-map address constants, NUM_CLASSES default.
- One sub-module, score_key_cmp: combinational, parameterised by ARITH_TYPE and DATA_WIDTH, output a_gt_b. Reused by later argmax/softmax blocks.

Test Plan:
- Fixed-point mode, scores 0..9 = {-5,3,7,7,-1,0,2,6,1,-8}, start pulse:
  - end_to_previous at T+1 only.
  - result_valid and done_irq at T+11.
  - class_index=2 (tie with 3 → lowest index).
- Float mode, scores all 0xBF800000 (-1.0) except score[8]=0x00000000 and score[4]=0x80000000 (-0): class_index=8. Read address 10 → 0x00000008.
- Float mode, scores all equal 0x40400000: class_index=0.
- Re-trigger: second start in SCAN ignored (no second end_to_previous). Start while in DONE with new scores where score[9] is max:
  - result_valid drops the next cycle.
  - result_valid reasserts 11 cycles later with class_index=9.
- Host interface, after result:
  - Read address 11 → 0x1; read address 5 → score[5] one cycle after rd_en.
  - riscv_clear → result_valid=0; read address 11 → 0x0.
  - riscv_clear and start in the same cycle → CAPTURE taken.
- reset asserted at T+5 during SCAN:
  - All outputs 0 the next cycle; no done_irq.
  - A following start completes normally.
